fc_layer_stream: RTL
====================

FC_LAYER_STREAM -- requirements
Module: fc_layer_stream

Interface
REQ-001 SHALL have parameter NUM_IN, default 49: number of input samples per vector, i.e. pooled values per frame.
REQ-002 SHALL have parameter NUM_OUT, default 10: number of output neurons.
REQ-003 SHALL have parameter Datawidth, default 16: signed two's-complement sample, weight and output width.
REQ-004 SHALL have parameter Frac, default 8: fractional bits of the fixed-point format.
REQ-005 SHALL have parameter ReLU, default 0: when 1, negative outputs are clamped to 0.
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all flops rise on posedge.
REQ-007 SHALL have port CLR, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port In, input, Datawidth bits: input sample.
REQ-009 SHALL have port Valid_IN, input, 1 bit: In is valid this cycle.
REQ-010 SHALL have port Ready_IN, output, 1 bit: the block accepts In this cycle.
REQ-011 SHALL have port Weight_Addr, output, clog2(NUM_OUT*(NUM_IN+1)) bits: address into the external weight store.
REQ-012 SHALL have port Weight_IN, input, Datawidth bits: combinational read data for Weight_Addr, valid in the same cycle.
REQ-013 SHALL have port Out, output, Datawidth bits: neuron result.
REQ-014 SHALL have port Out_Index, output, clog2(NUM_OUT) bits: neuron number of Out.
REQ-015 SHALL have port Valid_OUT, output, 1 bit: single-cycle strobe qualifying Out and Out_Index.

Function
REQ-016 SHALL implement FSM states LOAD, MAC, BIAS, EMIT.
REQ-017 In LOAD, SHALL drive Ready_IN=1 and, on each Valid_IN=1 cycle, store In into buffer[k] and increment k.
REQ-018 SHALL transition LOAD->MAC on the edge accepting sample NUM_IN-1, and clear k, i, o and the accumulator.
REQ-019 In MAC, SHALL drive Weight_Addr=o*(NUM_IN+1)+i and accumulate acc+=buffer[i]*Weight_IN for i=0..NUM_IN-1, one product per cycle.
REQ-020 SHALL transition MAC->BIAS after i=NUM_IN-1.
REQ-021 In BIAS, SHALL drive Weight_Addr=o*(NUM_IN+1)+NUM_IN and add Weight_IN<<<Frac to acc.
REQ-022 BIAS->EMIT: SHALL register Out=post(acc>>>Frac) and Out_Index=o, and drive Valid_OUT=1 for the EMIT cycle only.
REQ-023 EMIT: SHALL go to MAC with o+1 and acc=0 if o<NUM_OUT-1, otherwise to LOAD.
REQ-024 Accumulator SHALL be signed, 2*Datawidth+clog2(NUM_IN+1) bits, and SHALL never wrap.
REQ-025 post(): SHALL apply the REQ-033/034 narrowing, then the ReLU clamp (Out=0 if negative and ReLU=1).
REQ-026 Latency: last accepted sample at edge t -> Valid_OUT high in cycle t+NUM_IN+2; subsequent outputs every NUM_IN+2 cycles.
REQ-027 Ready_IN SHALL be 0 outside LOAD; Valid_IN is ignored there, with no buffer write and no count change.
REQ-028 Weight_Addr SHALL be 0 in LOAD and EMIT.
REQ-029 Out and Out_Index SHALL hold their last value between strobes.
REQ-030 A vector interrupted by reset SHALL be discarded; no partial output is produced.

Reset
REQ-031 On CLR=0 (asynchronous), SHALL set state=LOAD; k, i, o, acc = 0; Out=0; Out_Index=0; Valid_OUT=0; Ready_IN resumes 1 once CLR deasserts.
REQ-032 Buffer contents need not be reset.

Configuration
REQ-033 With macro FC_SATURATE_EN defined, the shifted accumulator SHALL saturate to [-2^(Datawidth-1), 2^(Datawidth-1)-1].
REQ-034 Without FC_SATURATE_EN, the shifted accumulator SHALL be truncated to its low Datawidth bits (wrap).

Verification (NUM_IN=4, NUM_OUT=2, Frac=8, Datawidth=16)
REQ-035 Basic: inputs 256,256,256,256; all weights 256; biases 0 -> Out=1024 with Out_Index 0, then Out=1024 with Out_Index 1; first Valid_OUT 6 cycles after the last accepted sample, second 6 cycles later.
REQ-036 Bias/sign: inputs 256,-256,512,0; weights neuron0 = 256,256,256,256, bias0=-128 -> Out=384; with ReLU=1 and bias0=-1024 -> Out=0.
REQ-037 Overflow: all inputs and weights 0x7FFF, bias 0 -> Out=0x7FFF with FC_SATURATE_EN defined, Out=0xFC00 without it.
REQ-038 Backpressure: Valid_IN held high through MAC/BIAS/EMIT -> Ready_IN=0 there, buffer unchanged, results identical to REQ-035; the next vector is accepted only after the final EMIT.
REQ-039 Reset mid-MAC: CLR=0 pulse during neuron 1 -> Valid_OUT=0 immediately, state LOAD, fresh vector of 4 samples yields correct outputs 0 and 1.
REQ-040 Gapped input: Valid_IN asserted every third cycle -> same outputs as REQ-035, latency measured from the 4th accepted sample.

Source files
------------

// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer: buffers one input vector, then runs one MAC per cycle per neuron
// against an external combinational weight store. Define FC_SATURATE_EN to saturate rather than wrap outputs.
module fc_layer_stream #(
  parameter int NUM_IN    = 49,
  parameter int NUM_OUT   = 10,
  parameter int Datawidth = 16,
  parameter int Frac      = 8,
  parameter int ReLU      = 0,
  localparam int AW = (NUM_OUT * (NUM_IN + 1) > 1) ? $clog2(NUM_OUT * (NUM_IN + 1)) : 1,
  localparam int OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                        CLK,
  input  logic                        CLR,
  input  logic signed [Datawidth-1:0] In,
  input  logic                        Valid_IN,
  output logic                        Ready_IN,
  output logic [AW-1:0]               Weight_Addr,
  input  logic signed [Datawidth-1:0] Weight_IN,
  output logic signed [Datawidth-1:0] Out,
  output logic [OW-1:0]               Out_Index,
  output logic                        Valid_OUT
);

  localparam int IW   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PW   = 2 * Datawidth;
  localparam int ACCW = 2 * Datawidth + $clog2(NUM_IN + 1);

  localparam logic [AW-1:0] STRIDE   = AW'(NUM_IN + 1);
  localparam logic [AW-1:0] BIAS_OFS = AW'(NUM_IN);
  localparam logic [IW-1:0] LAST_I   = IW'(NUM_IN - 1);
  localparam logic [OW-1:0] LAST_O   = OW'(NUM_OUT - 1);

  typedef enum logic [1:0] {LOAD, MAC, BIAS, EMIT} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               k_q, k_d;
  logic [IW-1:0]               i_q, i_d;
  logic [OW-1:0]               o_q, o_d;
  logic [AW-1:0]               base_q, base_d;
  logic signed [ACCW-1:0]      acc_q, acc_d;
  logic signed [Datawidth-1:0] out_q, out_d;
  logic [OW-1:0]               idx_q, idx_d;
  logic signed [Datawidth-1:0] buf_q [NUM_IN];

  logic signed [Datawidth-1:0] sample;
  logic signed [PW-1:0]        prod;
  logic signed [ACCW-1:0]      prod_ext;
  logic signed [ACCW-1:0]      bias_ext;
  logic signed [ACCW-1:0]      acc_fin;
  logic signed [Datawidth-1:0] narrowed;
  logic signed [Datawidth-1:0] post_val;
  logic                        accept;

  assign sample   = buf_q[i_q];
  assign prod     = PW'(sample) * PW'(Weight_IN);
  assign prod_ext = ACCW'(prod);
  // Bias is stored in the same Q format as the samples, so it is aligned to the product scale.
  assign bias_ext = ACCW'(Weight_IN) <<< Frac;
  assign acc_fin  = acc_q + bias_ext;

`ifdef FC_SATURATE_EN
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-Datawidth+1){1'b0}}, {(Datawidth-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-Datawidth+1){1'b1}}, {(Datawidth-1){1'b0}}};
  logic signed [ACCW-1:0] acc_shr;

  assign acc_shr = acc_fin >>> Frac;

  always_comb begin
    narrowed = acc_shr[Datawidth-1:0];
    if (acc_shr > SAT_MAX) begin
      narrowed = {1'b0, {(Datawidth-1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      narrowed = {1'b1, {(Datawidth-1){1'b0}}};
    end
  end
`else
  // Low Datawidth bits of (acc >>> Frac), i.e. a wrapping narrow.
  assign narrowed = acc_fin[Frac +: Datawidth];
`endif

  assign post_val = (ReLU != 0 && narrowed[Datawidth-1]) ? '0 : narrowed;

  assign Ready_IN  = (state_q == LOAD) && CLR;
  assign accept    = Ready_IN && Valid_IN;
  assign Valid_OUT = (state_q == EMIT);
  assign Out       = out_q;
  assign Out_Index = idx_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    o_d         = o_q;
    base_d      = base_q;
    acc_d       = acc_q;
    out_d       = out_q;
    idx_d       = idx_q;
    Weight_Addr = '0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (k_q == LAST_I) begin
            state_d = MAC;
            k_d     = '0;
            i_d     = '0;
            o_d     = '0;
            base_d  = '0;
            acc_d   = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      MAC: begin
        Weight_Addr = base_q + AW'(i_q);
        acc_d       = acc_q + prod_ext;
        if (i_q == LAST_I) begin
          state_d = BIAS;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      BIAS: begin
        Weight_Addr = base_q + BIAS_OFS;
        acc_d       = acc_fin;
        out_d       = post_val;
        idx_d       = o_q;
        state_d     = EMIT;
      end
      EMIT: begin
        acc_d = '0;
        i_d   = '0;
        if (o_q != LAST_O) begin
          o_d     = o_q + 1'b1;
          base_d  = base_q + STRIDE;
          state_d = MAC;
        end else begin
          o_d     = '0;
          base_d  = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= LOAD;
      k_q     <= '0;
      i_q     <= '0;
      o_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      o_q     <= o_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
    end
  end

  // Sample buffer is plain storage; its contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      buf_q[k_q] <= In;
    end
  end

endmodule
